pmem_arbiter: RTL and testbench

Two-client arbiter between the instruction-cache and data-cache line ports and the single physical-memory port.
- Serializes 128-bit line reads and writes onto one 16-bit-address pmem interface.
- Grants on ties by round-robin.
- Latches each granted request so client-side changes mid-transaction cannot disturb memory.
- Sits directly upstream of physical_memory and replaces the single-master connection at the mp3 top level.

---
 rtl/pmem_arbiter.sv | 116 +++++++++++
 tb/tb_pmem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - two-client round-robin arbiter onto a single physical-memory line port
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last_grant_d;   // 1: dcache was granted most recently
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_address;
    logic [LINE_W-1:0]   r_wdata;

    logic                w_req_i;
    logic                w_req_d;
    logic                w_grant_d;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_address;
    logic [LINE_W-1:0]   w_sel_wdata;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    // dcache wins when it is alone, or on a tie when icache was served last
    assign w_grant_d = w_req_d & (~w_req_i | ~r_last_grant_d);

    // A write strobe dominates a simultaneous read strobe from the same client
    assign w_sel_write   = w_grant_d ? d_write   : i_write;
    assign w_sel_address = w_grant_d ? d_address : i_address;
    assign w_sel_wdata   = w_grant_d ? d_wdata   : i_wdata;

    // Arbitration FSM: grant in IDLE, hold latched op in BUSY, one dead cycle in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_last_grant_d <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_address      <= '0;
            r_wdata        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_i | w_req_d) begin
                        r_address      <= w_sel_address;
                        r_wdata        <= w_sel_wdata;
                        r_pmem_write   <= w_sel_write;
                        r_pmem_read    <= ~w_sel_write;
                        r_last_grant_d <= w_grant_d;
                        r_state        <= w_grant_d ? ST_BUSY_D : ST_BUSY_I;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion is forwarded only to the client that owns the in-flight op
    assign i_resp = (r_state == ST_BUSY_I) & pmem_resp;
    assign d_resp = (r_state == ST_BUSY_D) & pmem_resp;

    // Read data fans out to both clients; each qualifies it with its own resp
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_address;
    assign pmem_wdata   = r_wdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - randomized bench for pmem_arbiter against a transaction-level model
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_resp, d_resp;
    logic [LW-1:0] i_rdata, d_rdata;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    // Client request state, index 0 = icache, 1 = dcache
    logic          c_rd [2];
    logic          c_wr [2];
    logic [AW-1:0] c_addr [2];
    logic [LW-1:0] c_wdata [2];

    // Transaction-level model: who owns memory, what they asked for, whose turn a tie is
    int            m_phase;      // 0 free, 1 transfer in flight, 2 post-completion gap
    int            m_owner;
    int            m_last;       // client granted most recently
    logic          m_wr_exp;
    logic [AW-1:0] m_addr_exp;
    logic [LW-1:0] m_wdata_exp;
    int            m_lat;
    int            n_grants [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (c_rd[0]),
        .i_write      (c_wr[0]),
        .i_address    (c_addr[0]),
        .i_wdata      (c_wdata[0]),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (c_rd[1]),
        .d_write      (c_wr[1]),
        .d_address    (c_addr[1]),
        .d_wdata      (c_wdata[1]),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_clients();
        for (int c = 0; c < 2; c++) begin
            c_rd[c] = 1'b0;
            c_wr[c] = 1'b0;
            c_addr[c] = '0;
            c_wdata[c] = '0;
        end
    endtask

    // One cycle: called just after a rising edge, returns just after the next one
    task automatic step(input bit allow_rand);
        logic exp_r, exp_w, ri, rd;
        exp_r = (m_phase == 1) && !m_wr_exp;
        exp_w = (m_phase == 1) && m_wr_exp;
        check("pmem_read", pmem_read, exp_r);
        check("pmem_write", pmem_write, exp_w);
        if (m_phase == 1) begin
            check("pmem_address", pmem_address, m_addr_exp);
            if (m_wr_exp) check("pmem_wdata", pmem_wdata, m_wdata_exp);
        end

        // Memory: answer the in-flight op after its latency, otherwise stray resp noise
        if (m_phase == 1) begin
            if (m_lat == 0) pmem_resp = 1'b1;
            else begin
                pmem_resp = 1'b0;
                m_lat--;
            end
        end else begin
            pmem_resp = ($urandom_range(0, 3) == 0);
        end
        pmem_rdata = rand_line();
        #1;
        check("i_resp", i_resp, (m_phase == 1) && (m_owner == 0) && pmem_resp);
        check("d_resp", d_resp, (m_phase == 1) && (m_owner == 1) && pmem_resp);
        check("i_rdata", i_rdata, pmem_rdata);
        check("d_rdata", d_rdata, pmem_rdata);

        // Completion ends the owner's request; phase advance happens below
        if (m_phase == 1 && pmem_resp) begin
            c_rd[m_owner] = 1'b0;
            c_wr[m_owner] = 1'b0;
        end

        if (allow_rand) begin
            for (int c = 0; c < 2; c++) begin
                if (!(c_rd[c] | c_wr[c])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 2))
                            0: begin c_rd[c] = 1'b1; c_wr[c] = 1'b0; end
                            1: begin c_rd[c] = 1'b0; c_wr[c] = 1'b1; end
                            default: begin c_rd[c] = 1'b1; c_wr[c] = 1'b1; end
                        endcase
                        c_addr[c]  = AW'($urandom);
                        c_wdata[c] = rand_line();
                    end
                end else if (m_phase == 1 && m_owner == c) begin
                    if ($urandom_range(0, 2) == 0) begin
                        c_addr[c]  = AW'($urandom);
                        c_wdata[c] = rand_line();
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    c_rd[c] = 1'b0;
                    c_wr[c] = 1'b0;
                end
            end
        end

        case (m_phase)
            0: begin
                ri = c_rd[0] | c_wr[0];
                rd = c_rd[1] | c_wr[1];
                if (ri || rd) begin
                    if (ri && rd) m_owner = 1 - m_last;
                    else          m_owner = rd ? 1 : 0;
                    m_last      = m_owner;
                    m_wr_exp    = c_wr[m_owner];
                    m_addr_exp  = c_addr[m_owner];
                    m_wdata_exp = c_wdata[m_owner];
                    m_lat       = $urandom_range(0, 4);
                    n_grants[m_owner]++;
                    m_phase     = 1;
                end
            end
            1: if (pmem_resp) m_phase = 2;
            default: m_phase = 0;
        endcase

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        clear_clients();
        m_phase = 0; m_owner = 0; m_last = 0; m_lat = 0;
        m_wr_exp = 1'b0; m_addr_exp = '0; m_wdata_exp = '0;
        n_grants[0] = 0; n_grants[1] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_read", pmem_read, 1'b0);
        check("reset_write", pmem_write, 1'b0);
        check("reset_address", pmem_address, '0);
        check("reset_wdata", pmem_wdata, '0);
        check("reset_i_resp", i_resp, 1'b0);
        check("reset_d_resp", d_resp, 1'b0);

        // First-ever tie: icache read vs dcache write, dcache must go first
        @(negedge clk);
        rst_n = 1'b1;
        c_rd[0] = 1'b1; c_addr[0] = 16'h0040; c_wdata[0] = rand_line();
        c_wr[1] = 1'b1; c_addr[1] = 16'h0080; c_wdata[1] = 128'h1;
        step(1'b0);
        check("first_tie_dcache_write", {pmem_write, pmem_read, pmem_address}, {1'b1, 1'b0, 16'h0080});

        for (int k = 0; k < 3000; k++) step(1'b1);

        // Reset in the middle of a transfer
        begin
            int guard;
            guard = 0;
            while (m_phase != 1 && guard < 200) begin
                step(1'b1);
                guard++;
            end
            check("reached_busy", (m_phase == 1), 1'b1);
        end
        pmem_resp = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_read", pmem_read, 1'b0);
        check("midreset_write", pmem_write, 1'b0);
        check("midreset_address", pmem_address, '0);
        clear_clients();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b1;
        #1;
        check("post_reset_i_resp", i_resp, 1'b0);
        check("post_reset_d_resp", d_resp, 1'b0);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        check("post_reset_idle_read", pmem_read, 1'b0);
        check("post_reset_idle_write", pmem_write, 1'b0);
        m_phase = 0; m_last = 0; m_lat = 0;

        // After reset the tie goes to dcache again; dcache asserts read and write together
        c_rd[0] = 1'b1; c_addr[0] = 16'h1230; c_wdata[0] = rand_line();
        c_rd[1] = 1'b1; c_wr[1] = 1'b1; c_addr[1] = 16'h0100; c_wdata[1] = rand_line();
        for (int k = 0; k < 2000; k++) step(k > 20);

        check("both_clients_served", (n_grants[0] > 100) && (n_grants[1] > 100), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
